// File: rtl/bram_port_arbiter.sv
// ---------------------------------------------------------------------------
// bram_port_arbiter
//
// Shares port B of the 32 KiB data BRAM between the CPU data interface
// (master 0) and the loader/DMA engine (master 1). At most one access is
// issued per cycle; read data returns one cycle after the grant on the shared
// o_rdata bus, qualified by the owning master's rvalid.
//
// Arbitration:
//   S_OPEN - master 0 wins by default; master 1 wins when master 0 is idle or
//            when the starvation guard has fired.
//   S_LOCK - entered when master 1 is granted with i_m1_lock=1. Master 1 owns
//            the port for up to BURST_MAX beats (the entry grant is beat 1).
//
// Build option: define ARB_STARVE_GUARD_EN to include the starvation counter
// that forces a master 1 win after MAX_WAIT denied cycles. Without it S_OPEN
// is strict master 0 priority.
//
// Parameters:
//   MAX_WAIT  (1..255) denied cycles before master 1 is forced to win
//   BURST_MAX (1..255) maximum beats master 1 may hold the port under lock
//
// Ports:
//   i_clk, i_rst_n                  clock, async active-low reset
//   i_mX_req/addr/wdata/we          master X request (we==0 means read)
//   i_m1_lock                       master 1 burst-ownership request
//   o_mX_gnt                        master X access issued this cycle
//   o_mX_rvalid                     master X read data valid on o_rdata
//   o_rdata                         shared read data
//   o_mem_en/addr/wdata/we          BRAM port B controls
//   i_mem_rdata                     BRAM read data (one cycle after o_mem_en)
// ---------------------------------------------------------------------------
module bram_port_arbiter #(
  parameter int MAX_WAIT  = 8,
  parameter int BURST_MAX = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_m0_req,
  input  logic [12:0] i_m0_addr,
  input  logic [31:0] i_m0_wdata,
  input  logic [3:0]  i_m0_we,
  output logic        o_m0_gnt,
  output logic        o_m0_rvalid,
  input  logic        i_m1_req,
  input  logic [12:0] i_m1_addr,
  input  logic [31:0] i_m1_wdata,
  input  logic [3:0]  i_m1_we,
  input  logic        i_m1_lock,
  output logic        o_m1_gnt,
  output logic        o_m1_rvalid,
  output logic [31:0] o_rdata,
  output logic        o_mem_en,
  output logic [12:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_we,
  input  logic [31:0] i_mem_rdata
);

  typedef enum logic {
    S_OPEN = 1'b0,
    S_LOCK = 1'b1
  } state_t;

  // A lock with BURST_MAX==1 would be exhausted by its own entry beat.
  localparam bit         LOCK_OK    = (BURST_MAX > 1);
  localparam logic [7:0] BURST_LAST = 8'(BURST_MAX - 1);

  state_t     state;
  logic [7:0] beat_cnt;
  logic       rd_pend;
  logic       rd_owner;
  logic       m0_win;
  logic       m1_win;
  logic       force_m1;
  logic       gnt0;
  logic       gnt1;

`ifdef ARB_STARVE_GUARD_EN
  localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

  logic [7:0] starve_cnt;

  // Counts consecutive denied cycles of a pending master 1 request and sits
  // at WAIT_LIMIT until master 1 is served or withdraws.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      starve_cnt <= '0;
    end else if (!i_m1_req || gnt1) begin
      starve_cnt <= '0;
    end else if (starve_cnt != WAIT_LIMIT) begin
      starve_cnt <= starve_cnt + 8'd1;
    end
  end

  assign force_m1 = (starve_cnt == WAIT_LIMIT);
`else
  // MAX_WAIT is legal only in 1..255, so this is constant 0: S_OPEN reduces
  // to strict master 0 priority.
  assign force_m1 = (MAX_WAIT == 0);
`endif

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    m0_win = 1'b0;
    m1_win = 1'b0;
    if (state == S_LOCK) begin
      m1_win = i_m1_req;
    end else begin
      m1_win = i_m1_req & (~i_m0_req | force_m1);
      m0_win = i_m0_req & ~m1_win;
    end
  end

  // NOTE: grants are combinational, so they are qualified with i_rst_n to
  // drop the moment reset asserts rather than at the next clock edge.
  assign gnt0     = i_rst_n & m0_win;
  assign gnt1     = i_rst_n & m1_win;
  assign o_m0_gnt = gnt0;
  assign o_m1_gnt = gnt1;
  assign o_mem_en = gnt0 | gnt1;

  always_comb begin
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_mem_we    = '0;
    if (gnt1) begin
      o_mem_addr  = i_m1_addr;
      o_mem_wdata = i_m1_wdata;
      o_mem_we    = i_m1_we;
    end else if (gnt0) begin
      o_mem_addr  = i_m0_addr;
      o_mem_wdata = i_m0_wdata;
      o_mem_we    = i_m0_we;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= S_OPEN;
      beat_cnt <= '0;
      rd_pend  <= 1'b0;
      rd_owner <= 1'b0;
    end else begin
      rd_pend <= o_mem_en & ~|o_mem_we;
      if (o_mem_en && ~|o_mem_we) begin
        rd_owner <= gnt1;
      end

      case (state)
        S_OPEN: begin
          if (gnt1 && i_m1_lock && LOCK_OK) begin
            state    <= S_LOCK;
            beat_cnt <= 8'd1;
          end
        end
        S_LOCK: begin
          // A request gap, a released lock, or the final permitted beat all
          // hand the port back to open arbitration.
          if (!i_m1_req || !i_m1_lock || beat_cnt == BURST_LAST) begin
            state    <= S_OPEN;
            beat_cnt <= '0;
          end else begin
            beat_cnt <= beat_cnt + 8'd1;
          end
        end
        default: begin
          state    <= S_OPEN;
          beat_cnt <= '0;
        end
      endcase
    end
  end

  assign o_m0_rvalid = rd_pend & ~rd_owner;
  assign o_m1_rvalid = rd_pend & rd_owner;
  // Held at zero outside a read return so the bus is quiet in reset.
  assign o_rdata     = rd_pend ? i_mem_rdata : '0;

endmodule

// File: tb/tb_bram_port_arbiter.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_bram_port_arbiter
//
// Two transaction queues feed the masters. Each cycle a reference model,
// written as plain port-ownership rules over a shadow memory, decides who
// should own the port; the expected port activity and read returns are
// queued, and an independent monitor on the falling edge compares them with
// whatever the DUT presents. A behavioural BRAM answers the DUT's port.
// ---------------------------------------------------------------------------
module tb_bram_port_arbiter;

  localparam int MAX_WAIT  = 8;
  localparam int BURST_MAX = 16;
`ifdef ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        i_clk;
  logic        i_rst_n;
  logic        i_m0_req;
  logic [12:0] i_m0_addr;
  logic [31:0] i_m0_wdata;
  logic [3:0]  i_m0_we;
  logic        o_m0_gnt;
  logic        o_m0_rvalid;
  logic        i_m1_req;
  logic [12:0] i_m1_addr;
  logic [31:0] i_m1_wdata;
  logic [3:0]  i_m1_we;
  logic        i_m1_lock;
  logic        o_m1_gnt;
  logic        o_m1_rvalid;
  logic [31:0] o_rdata;
  logic        o_mem_en;
  logic [12:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_we;
  logic [31:0] i_mem_rdata;

  bram_port_arbiter #(.MAX_WAIT(MAX_WAIT), .BURST_MAX(BURST_MAX)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_m0_req(i_m0_req), .i_m0_addr(i_m0_addr), .i_m0_wdata(i_m0_wdata),
    .i_m0_we(i_m0_we), .o_m0_gnt(o_m0_gnt), .o_m0_rvalid(o_m0_rvalid),
    .i_m1_req(i_m1_req), .i_m1_addr(i_m1_addr), .i_m1_wdata(i_m1_wdata),
    .i_m1_we(i_m1_we), .i_m1_lock(i_m1_lock), .o_m1_gnt(o_m1_gnt),
    .o_m1_rvalid(o_m1_rvalid), .o_rdata(o_rdata),
    .o_mem_en(o_mem_en), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .o_mem_we(o_mem_we), .i_mem_rdata(i_mem_rdata)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Behavioural BRAM port B: byte writes and a registered read.
  logic [31:0] bram [0:8191];
  always @(posedge i_clk) begin
    if (o_mem_en) begin
      for (int b = 0; b < 4; b++)
        if (o_mem_we[b]) bram[o_mem_addr][8*b +: 8] <= o_mem_wdata[8*b +: 8];
      i_mem_rdata <= bram[o_mem_addr];
    end
  end

  typedef struct {
    logic [12:0] addr;
    logic [31:0] wdata;
    logic [3:0]  we;
    logic        lock;
  } txn_t;

  typedef struct {
    int          cyc;
    logic        g0;
    logic        g1;
    logic [12:0] addr;
    logic [31:0] wdata;
    logic [3:0]  we;
  } port_exp_t;

  typedef struct {
    int          due;
    logic        owner;
    logic [31:0] data;
  } rd_exp_t;

  txn_t      q0[$];
  txn_t      q1[$];
  port_exp_t port_q[$];
  rd_exp_t   rd_q[$];
  logic [31:0] shadow [0:8191];

  int cyc;
  bit mon_en;
  int total;
  int bad;

  // Reference model state: is master 1 holding a burst, how many beats it
  // has used, how many cycles it has been kept waiting.
  bit mdl_burst;
  int mdl_beats_used;
  int mdl_waited;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic txn_t mk(input logic [12:0] a, input logic [31:0] d,
                              input logic [3:0] we, input logic lk);
    txn_t t;
    t.addr = a; t.wdata = d; t.we = we; t.lock = lk;
    return t;
  endfunction

  function automatic txn_t rand_txn(input bit allow_lock);
    txn_t t;
    t.addr  = 13'($urandom_range(0, 31));
    t.wdata = $urandom;
    t.we    = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
    t.lock  = allow_lock && ($urandom_range(0, 2) == 0);
    return t;
  endfunction

  task automatic mdl_reset();
    mdl_burst      = 1'b0;
    mdl_beats_used = 0;
    mdl_waited     = 0;
  endtask

  // One clock of stimulus: present each enabled master's head transaction,
  // predict who owns the port, and record what the DUT must show.
  task automatic step(input bit en0, input bit en1);
    txn_t      t0, t1, tw;
    bit        r0, r1, g0, g1, starved;
    port_exp_t pe;
    rd_exp_t   re;
    @(posedge i_clk);
    #2;
    cyc++;
    r0 = en0 && (q0.size() > 0);
    r1 = en1 && (q1.size() > 0);
    t0 = r0 ? q0[0] : mk('0, '0, '0, 1'b0);
    t1 = r1 ? q1[0] : mk('0, '0, '0, 1'b0);
    i_m0_req = r0; i_m0_addr = t0.addr; i_m0_wdata = t0.wdata; i_m0_we = t0.we;
    i_m1_req = r1; i_m1_addr = t1.addr; i_m1_wdata = t1.wdata; i_m1_we = t1.we;
    i_m1_lock = t1.lock;

    if (mdl_burst) begin
      g1 = r1;
      g0 = 1'b0;
    end else begin
      starved = GUARD && (mdl_waited >= MAX_WAIT);
      g1 = r1 && (!r0 || starved);
      g0 = r0 && !g1;
    end

    tw = g1 ? t1 : t0;
    pe.cyc = cyc; pe.g0 = g0; pe.g1 = g1;
    pe.addr  = (g0 || g1) ? tw.addr  : 13'h0;
    pe.wdata = (g0 || g1) ? tw.wdata : 32'h0;
    pe.we    = (g0 || g1) ? tw.we    : 4'h0;
    port_q.push_back(pe);

    if (g0 || g1) begin
      if (tw.we == 4'h0) begin
        re.due = cyc + 1; re.owner = g1; re.data = shadow[tw.addr];
        rd_q.push_back(re);
      end else begin
        for (int b = 0; b < 4; b++)
          if (tw.we[b]) shadow[tw.addr][8*b +: 8] = tw.wdata[8*b +: 8];
      end
    end

    if (mdl_burst) begin
      if (!r1) begin
        mdl_burst = 1'b0; mdl_beats_used = 0;
      end else begin
        mdl_beats_used++;
        if (!t1.lock || mdl_beats_used >= BURST_MAX) begin
          mdl_burst = 1'b0; mdl_beats_used = 0;
        end
      end
    end else if (g1 && t1.lock && BURST_MAX > 1) begin
      mdl_burst = 1'b1; mdl_beats_used = 1;
    end

    if (r1 && !g1) mdl_waited = (mdl_waited < MAX_WAIT) ? mdl_waited + 1 : MAX_WAIT;
    else           mdl_waited = 0;

    if (g0) q0.delete(0);
    if (g1) q1.delete(0);
  endtask

  task automatic drain(input int limit);
    for (int n = 0; n < limit && (q0.size() > 0 || q1.size() > 0); n++) step(1'b1, 1'b1);
    check("drain_left", 32'(q0.size() + q1.size()), 32'd0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_m0_gnt"},    {31'd0, o_m0_gnt},    32'd0);
    check({tag, "_m1_gnt"},    {31'd0, o_m1_gnt},    32'd0);
    check({tag, "_m0_rvalid"}, {31'd0, o_m0_rvalid}, 32'd0);
    check({tag, "_m1_rvalid"}, {31'd0, o_m1_rvalid}, 32'd0);
    check({tag, "_mem_en"},    {31'd0, o_mem_en},    32'd0);
    check({tag, "_mem_we"},    {28'd0, o_mem_we},    32'd0);
    check({tag, "_mem_addr"},  {19'd0, o_mem_addr},  32'd0);
    check({tag, "_rdata"},     o_rdata,              32'd0);
  endtask

  // Monitor: compares port activity for the current cycle and every read
  // return the DUT presents against the queued expectations.
  always @(negedge i_clk) begin : monitor
    port_exp_t pe;
    rd_exp_t   re;
    if (mon_en) begin
      if (port_q.size() > 0 && port_q[0].cyc == cyc) begin
        pe = port_q.pop_front();
        check("m0_gnt",    {31'd0, o_m0_gnt},   {31'd0, pe.g0});
        check("m1_gnt",    {31'd0, o_m1_gnt},   {31'd0, pe.g1});
        check("mem_en",    {31'd0, o_mem_en},   {31'd0, pe.g0 | pe.g1});
        check("mem_addr",  {19'd0, o_mem_addr}, {19'd0, pe.addr});
        check("mem_wdata", o_mem_wdata,         pe.wdata);
        check("mem_we",    {28'd0, o_mem_we},   {28'd0, pe.we});
      end
      if (o_m0_rvalid || o_m1_rvalid) begin
        if (rd_q.size() == 0) begin
          check("spurious_rvalid", {30'd0, o_m1_rvalid, o_m0_rvalid}, 32'd0);
        end else begin
          re = rd_q.pop_front();
          check("rvalid_owner", {30'd0, o_m1_rvalid, o_m0_rvalid}, re.owner ? 32'd2 : 32'd1);
          check("rvalid_cycle", 32'(cyc), 32'(re.due));
          check("rdata", o_rdata, re.data);
        end
      end else if (rd_q.size() > 0 && rd_q[0].due <= cyc) begin
        re = rd_q.pop_front();
        check("missing_rvalid", 32'd0, re.owner ? 32'd2 : 32'd1);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded its time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : main
    total = 0; bad = 0; cyc = 0; mon_en = 1'b0;
    mdl_reset();
    i_rst_n = 1'b0;
    i_m0_req = 1'b1; i_m0_addr = 13'h010; i_m0_wdata = '0; i_m0_we = '0;
    i_m1_req = 1'b1; i_m1_addr = 13'h020; i_m1_wdata = '0; i_m1_we = '0;
    i_m1_lock = 1'b1;
    for (int i = 0; i < 8192; i++) begin
      bram[i]   = (32'(i) * 32'h01000193) ^ 32'hA5A5A5A5;
      shadow[i] = bram[i];
    end
    bram[13'h010] = 32'h12345678; shadow[13'h010] = 32'h12345678;
    bram[13'h005] = 32'hFFFFFFFF; shadow[13'h005] = 32'hFFFFFFFF;

    // Reset state, with both masters requesting.
    repeat (3) @(posedge i_clk);
    #1 check_quiet("reset");
    i_m0_req = 1'b0; i_m1_req = 1'b0; i_m1_lock = 1'b0;
    @(posedge i_clk);
    #3 i_rst_n = 1'b1;
    mon_en = 1'b1;

    // Single master 0 read.
    q0.push_back(mk(13'h010, 32'h0, 4'h0, 1'b0));
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);

    // Byte write by master 0, read back by master 1, then back-to-back reads.
    q0.push_back(mk(13'h005, 32'h0000AB00, 4'b0010, 1'b0));
    step(1'b1, 1'b0);
    q1.push_back(mk(13'h005, 32'h0, 4'h0, 1'b0));
    step(1'b0, 1'b1);
    q0.push_back(mk(13'h010, 32'h0, 4'h0, 1'b0));
    step(1'b1, 1'b0);
    q1.push_back(mk(13'h005, 32'h0, 4'h0, 1'b0));
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);

    // Continuous contention, no lock.
    for (int i = 0; i < 27; i++) begin
      q0.push_back(mk(13'(64 + i), 32'h0, 4'h0, 1'b0));
      q1.push_back(mk(13'(128 + i), 32'h0, 4'h0, 1'b0));
    end
    repeat (27) step(1'b1, 1'b1);
    drain(200);

    // Locked write burst longer than BURST_MAX with master 0 waiting.
    for (int i = 0; i < 20; i++) q1.push_back(mk(13'(200 + i), $urandom, 4'hF, 1'b1));
    for (int i = 0; i < 4; i++)  q0.push_back(mk(13'(200 + i), 32'h0, 4'h0, 1'b0));
    step(1'b0, 1'b1);
    repeat (20) step(1'b1, 1'b1);
    drain(200);

    // Lock released early on the third beat.
    q1.push_back(mk(13'd240, 32'h11111111, 4'hF, 1'b1));
    q1.push_back(mk(13'd241, 32'h22222222, 4'hF, 1'b1));
    q1.push_back(mk(13'd242, 32'h33333333, 4'hF, 1'b0));
    q0.push_back(mk(13'd241, 32'h0, 4'h0, 1'b0));
    step(1'b0, 1'b1);
    repeat (3) step(1'b1, 1'b1);
    drain(50);

    // Asynchronous reset one cycle after a master 1 read grant in a burst.
    for (int i = 0; i < 6; i++) q1.push_back(mk(13'(300 + i), 32'h0, 4'h0, 1'b1));
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    @(posedge i_clk);
    #2;
    mon_en = 1'b0;
    i_rst_n = 1'b0;
    #1 check_quiet("midreset");
    port_q.delete(); rd_q.delete(); q0.delete(); q1.delete();
    i_m0_req = 1'b1;
    repeat (2) @(posedge i_clk);
    #1 check_quiet("midreset_hold");
    i_m0_req = 1'b0; i_m1_req = 1'b0; i_m1_lock = 1'b0;
    @(posedge i_clk);
    #3 i_rst_n = 1'b1;
    mdl_reset();
    mon_en = 1'b1;
    repeat (3) step(1'b0, 1'b0);
    for (int i = 0; i < 27; i++) begin
      q0.push_back(mk(13'(400 + i), 32'h0, 4'h0, 1'b0));
      q1.push_back(mk(13'(500 + i), 32'h0, 4'h0, 1'b1));
    end
    repeat (27) step(1'b1, 1'b1);
    drain(200);

    // Randomised traffic over a small address window.
    for (int n = 0; n < 600; n++) begin
      if (q0.size() < 3 && $urandom_range(0, 1) == 1) q0.push_back(rand_txn(1'b0));
      if (q1.size() < 3 && $urandom_range(0, 1) == 1) q1.push_back(rand_txn(1'b1));
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
    end
    drain(400);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
